// File: rtl/gfx_line_raster_if.sv
// Stream/control bundle for gfx_line_raster.
// Parameters: POINT_WIDTH (integer bits), SUBPIXEL_WIDTH (fractional bits).
// Requester side (master): p0/p1 fixed-point endpoints, start_i, abort_i, ready_i
//   (+ clip_xmin/xmax/ymin/ymax_i when GFX_LINE_CLIP_EN is defined).
// Rasteriser side (slave): valid_o, x_o, y_o, last_o, busy_o, done_o.
interface gfx_line_raster_if #(
    parameter int unsigned POINT_WIDTH    = 16,
    parameter int unsigned SUBPIXEL_WIDTH = 16
);
    localparam int unsigned CW = POINT_WIDTH + SUBPIXEL_WIDTH;

    logic signed [CW-1:0]          p0_x_i;
    logic signed [CW-1:0]          p0_y_i;
    logic signed [CW-1:0]          p1_x_i;
    logic signed [CW-1:0]          p1_y_i;
    logic                          start_i;
    logic                          abort_i;
    logic                          ready_i;
    logic                          valid_o;
    logic signed [POINT_WIDTH-1:0] x_o;
    logic signed [POINT_WIDTH-1:0] y_o;
    logic                          last_o;
    logic                          busy_o;
    logic                          done_o;
`ifdef GFX_LINE_CLIP_EN
    logic signed [POINT_WIDTH-1:0] clip_xmin_i;
    logic signed [POINT_WIDTH-1:0] clip_xmax_i;
    logic signed [POINT_WIDTH-1:0] clip_ymin_i;
    logic signed [POINT_WIDTH-1:0] clip_ymax_i;

    modport master (
        output p0_x_i, p0_y_i, p1_x_i, p1_y_i, start_i, abort_i, ready_i,
        output clip_xmin_i, clip_xmax_i, clip_ymin_i, clip_ymax_i,
        input  valid_o, x_o, y_o, last_o, busy_o, done_o
    );
    modport slave (
        input  p0_x_i, p0_y_i, p1_x_i, p1_y_i, start_i, abort_i, ready_i,
        input  clip_xmin_i, clip_xmax_i, clip_ymin_i, clip_ymax_i,
        output valid_o, x_o, y_o, last_o, busy_o, done_o
    );
`else
    modport master (
        output p0_x_i, p0_y_i, p1_x_i, p1_y_i, start_i, abort_i, ready_i,
        input  valid_o, x_o, y_o, last_o, busy_o, done_o
    );
    modport slave (
        input  p0_x_i, p0_y_i, p1_x_i, p1_y_i, start_i, abort_i, ready_i,
        output valid_o, x_o, y_o, last_o, busy_o, done_o
    );
`endif
endinterface

// File: rtl/gfx_line_raster.sv
// Bresenham line rasteriser: floors two fixed-point endpoints and streams every
// integer pixel from p0 to p1 (all octants) over a valid/ready handshake.
// Ports: clk_i, rst_n_i (synchronous, active low), bus (gfx_line_raster_if.slave).
// Optional rectangle clipping is compiled in with `define GFX_LINE_CLIP_EN.
module gfx_line_raster #(
    parameter int unsigned POINT_WIDTH    = 16,
    parameter int unsigned SUBPIXEL_WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    gfx_line_raster_if.slave bus
);
    localparam int unsigned PW = POINT_WIDTH;
    localparam int unsigned SW = SUBPIXEL_WIDTH;
    localparam int unsigned CW = PW + SW;
    localparam int unsigned DW = PW + 1;
    localparam int unsigned EW = PW + 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic signed [PW-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic signed [PW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic signed [EW-1:0] err_q, err_d;
    logic [DW-1:0]        count_q, count_d, dmaj_q, dmaj_d, dmin_q, dmin_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic                 x_major_q, x_major_d;
    logic                 valid_q, valid_d, last_q, last_d;
    logic                 busy_q, busy_d, done_q, done_d;
`ifdef GFX_LINE_CLIP_EN
    logic signed [PW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
`endif

    logic signed [DW-1:0] diff_x_c, diff_y_c;
    logic [DW-1:0]        abs_x_c, abs_y_c;
    logic signed [EW-1:0] e_next_c, dmin_e_c, dmaj_e_c;
    logic signed [EW:0]   twice_c, dmaj_cmp_c;
    logic                 minor_step_c, advance_c, finish_c;
    logic signed [PW-1:0] nx_c, ny_c;
    logic                 in_load_c, in_step_c;
    logic                 frac_unused_c;

    // Fractional bits are discarded by the floor.
    assign frac_unused_c = ^{bus.p0_x_i[SW-1:0], bus.p0_y_i[SW-1:0],
                             bus.p1_x_i[SW-1:0], bus.p1_y_i[SW-1:0]};

    // Setup deltas and the per-step walker arithmetic.
    always_comb begin
        diff_x_c     = DW'(x1_q) - DW'(x0_q);
        diff_y_c     = DW'(y1_q) - DW'(y0_q);
        abs_x_c      = $unsigned(diff_x_c[DW-1] ? -diff_x_c : diff_x_c);
        abs_y_c      = $unsigned(diff_y_c[DW-1] ? -diff_y_c : diff_y_c);
        dmin_e_c     = $signed(EW'(dmin_q));
        dmaj_e_c     = $signed(EW'(dmaj_q));
        e_next_c     = err_q + dmin_e_c;
        twice_c      = $signed({e_next_c, 1'b0});
        dmaj_cmp_c   = $signed((EW+1)'(dmaj_q));
        // Ties (2e' == dmaj) step the minor axis.
        minor_step_c = (twice_c >= dmaj_cmp_c);
        nx_c         = cur_x_q;
        ny_c         = cur_y_q;
        if (x_major_q || minor_step_c) begin
            nx_c = sx_neg_q ? cur_x_q - PW'(1) : cur_x_q + PW'(1);
        end
        if (!x_major_q || minor_step_c) begin
            ny_c = sy_neg_q ? cur_y_q - PW'(1) : cur_y_q + PW'(1);
        end
`ifdef GFX_LINE_CLIP_EN
        in_load_c = (x0_q >= xmin_q) && (x0_q <= xmax_q) && (y0_q >= ymin_q) && (y0_q <= ymax_q);
        in_step_c = (nx_c >= xmin_q) && (nx_c <= xmax_q) && (ny_c >= ymin_q) && (ny_c <= ymax_q);
`else
        in_load_c = 1'b1;
        in_step_c = 1'b1;
`endif
        // Hidden (clipped) pixels advance without waiting for ready.
        advance_c = (state_q == S_RUN) && (!valid_q || bus.ready_i);
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        err_d     = err_q;
        count_d   = count_q;
        dmaj_d    = dmaj_q;
        dmin_d    = dmin_q;
        sx_neg_d  = sx_neg_q;
        sy_neg_d  = sy_neg_q;
        x_major_d = x_major_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        finish_c  = 1'b0;
`ifdef GFX_LINE_CLIP_EN
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_PREP;
                    busy_d  = 1'b1;
                    x0_d    = bus.p0_x_i[CW-1:SW];
                    y0_d    = bus.p0_y_i[CW-1:SW];
                    x1_d    = bus.p1_x_i[CW-1:SW];
                    y1_d    = bus.p1_y_i[CW-1:SW];
`ifdef GFX_LINE_CLIP_EN
                    xmin_d  = bus.clip_xmin_i;
                    xmax_d  = bus.clip_xmax_i;
                    ymin_d  = bus.clip_ymin_i;
                    ymax_d  = bus.clip_ymax_i;
`endif
                end
            end
            S_PREP: begin
                if (bus.abort_i) begin
                    finish_c = 1'b1;
                end else begin
                    state_d   = S_RUN;
                    sx_neg_d  = diff_x_c[DW-1];
                    sy_neg_d  = diff_y_c[DW-1];
                    x_major_d = (abs_x_c >= abs_y_c);
                    dmaj_d    = x_major_d ? abs_x_c : abs_y_c;
                    dmin_d    = x_major_d ? abs_y_c : abs_x_c;
                    cur_x_d   = x0_q;
                    cur_y_d   = y0_q;
                    err_d     = '0;
                    count_d   = dmaj_d;
                    valid_d   = in_load_c;
                    last_d    = in_load_c && (dmaj_d == '0);
                end
            end
            S_RUN: begin
                if (bus.abort_i) begin
                    finish_c = 1'b1;
                end else if (advance_c) begin
                    if (count_q == '0) begin
                        finish_c = 1'b1;
                    end else begin
                        cur_x_d = nx_c;
                        cur_y_d = ny_c;
                        err_d   = minor_step_c ? e_next_c - dmaj_e_c : e_next_c;
                        count_d = count_q - DW'(1);
                        valid_d = in_step_c;
                        last_d  = in_step_c && (count_q == DW'(1));
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
        // Line completed or aborted.
        if (finish_c) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            err_q     <= '0;
            count_q   <= '0;
            dmaj_q    <= '0;
            dmin_q    <= '0;
            sx_neg_q  <= 1'b0;
            sy_neg_q  <= 1'b0;
            x_major_q <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef GFX_LINE_CLIP_EN
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymin_q    <= '0;
            ymax_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            err_q     <= err_d;
            count_q   <= count_d;
            dmaj_q    <= dmaj_d;
            dmin_q    <= dmin_d;
            sx_neg_q  <= sx_neg_d;
            sy_neg_q  <= sy_neg_d;
            x_major_q <= x_major_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef GFX_LINE_CLIP_EN
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
`endif
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.x_o     = cur_x_q;
    assign bus.y_o     = cur_y_q;
    assign bus.last_o  = last_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule
